// File: rtl/car_drive_controller.sv
`timescale 1ns/1ps
// Drive sequencer for the line-following car: debounced track sensing, obstacle
// hysteresis, lost-line recovery with timeout, and an enable gate.
module car_drive_controller #(
   parameter int unsigned DEBOUNCE_CYC = 100_000,
   parameter logic [19:0] STOP_DIST    = 20'd3000,
   parameter logic [19:0] RESUME_DIST  = 20'd3500,
   parameter int unsigned CLEAR_CYC    = 5_000_000,
   parameter int unsigned LOST_TIMEOUT = 200_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        left_track,
   input  logic        mid_track,
   input  logic        right_track,
   input  logic [19:0] distance,
   output logic [1:0]  mode,
   output logic [1:0]  l_in,
   output logic [1:0]  r_in,
   output logic        blocked,
   output logic [2:0]  state_dbg
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
   localparam int CLR_W  = $clog2(CLEAR_CYC + 1);
   localparam int LOST_W = $clog2(LOST_TIMEOUT + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [CLR_W-1:0]  CLR_LAST  = CLR_W'(CLEAR_CYC - 1);
   localparam logic [CLR_W-1:0]  CLR_SAT   = CLR_W'(CLEAR_CYC);
   localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_TIMEOUT - 1);
   localparam logic [LOST_W-1:0] LOST_SAT  = LOST_W'(LOST_TIMEOUT);

   localparam logic [1:0] MODE_FWD   = 2'b00;
   localparam logic [1:0] MODE_LEFT  = 2'b01;
   localparam logic [1:0] MODE_RIGHT = 2'b10;
   localparam logic [1:0] MODE_STOP  = 2'b11;

   localparam logic [1:0] PIN_COAST = 2'b00;
   localparam logic [1:0] PIN_FWD   = 2'b01;
   localparam logic [1:0] PIN_REV   = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FOLLOW  = 3'd1,
      ST_BLOCKED = 3'd2,
      ST_LOST    = 3'd3,
      ST_HALT    = 3'd4
   } state_t;

   logic [2:0]        trk_p0;
   logic [2:0]        trk_p1;
   logic [2:0]        trk_last;
   logic [2:0]        trk_db;
   logic [DB_W-1:0]   db_cnt;
   state_t            state;
   state_t            nxt_state;
   logic [CLR_W-1:0]  clr_cnt;
   logic [LOST_W-1:0] lost_cnt;
   logic              last_left;
   logic              obstacle;
   logic              clear;
   logic [1:0]        follow_mode;

   assign obstacle  = (distance != 20'd0) && (distance < STOP_DIST);
   assign clear     = (distance == 20'd0) || (distance >= RESUME_DIST);
   assign state_dbg = state;

   // Stage p0/p1: two-flop synchronizer for the asynchronous track sensors
   always_ff @(posedge clk) begin
      trk_p0 <= {left_track, mid_track, right_track};
      trk_p1 <= trk_p0;
   end

   // Debounce: the synchronized vector must sit still for DEBOUNCE_CYC cycles
   always_ff @(posedge clk) begin
      if (!rst) begin
         trk_last <= 3'b000;
         db_cnt   <= '0;
         trk_db   <= 3'b000;
      end else if (trk_p1 != trk_last) begin
         trk_last <= trk_p1;
         db_cnt   <= '0;
      end else if (db_cnt == DB_LAST) begin
         trk_db   <= trk_last;
      end else begin
         db_cnt   <= db_cnt + 1'b1;
      end
   end

   always_comb begin
      follow_mode = MODE_STOP;
      case (trk_db)
         3'b010, 3'b111, 3'b101: follow_mode = MODE_FWD;
         3'b100, 3'b110:         follow_mode = MODE_LEFT;
         3'b001, 3'b011:         follow_mode = MODE_RIGHT;
         default:                follow_mode = MODE_STOP;
      endcase
   end

   always_comb begin
      nxt_state = state;
      case (state)
         ST_IDLE:    nxt_state = ST_FOLLOW;
         ST_FOLLOW: begin
            if (obstacle)               nxt_state = ST_BLOCKED;
            else if (trk_db == 3'b000)  nxt_state = ST_LOST;
         end
         ST_BLOCKED: begin
            if (clear && clr_cnt == CLR_LAST) nxt_state = ST_FOLLOW;
         end
         ST_LOST: begin
            if (obstacle)                     nxt_state = ST_BLOCKED;
            else if (trk_db != 3'b000)        nxt_state = ST_FOLLOW;
            else if (lost_cnt == LOST_LAST)   nxt_state = ST_HALT;
         end
         ST_HALT:    nxt_state = ST_HALT;
         default:    nxt_state = ST_IDLE;
      endcase
      if (!en) nxt_state = ST_IDLE;
   end

   // Outputs are decoded from the next state so they move with state_dbg
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         mode      <= MODE_STOP;
         l_in      <= PIN_COAST;
         r_in      <= PIN_COAST;
         blocked   <= 1'b0;
         clr_cnt   <= '0;
         lost_cnt  <= '0;
         last_left <= 1'b1;
      end else begin
         state   <= nxt_state;
         blocked <= (nxt_state == ST_BLOCKED);

         if (state != ST_BLOCKED || !clear) clr_cnt <= '0;
         else if (clr_cnt != CLR_SAT)        clr_cnt <= clr_cnt + 1'b1;

         if (state != ST_LOST)               lost_cnt <= '0;
         else if (lost_cnt != LOST_SAT)      lost_cnt <= lost_cnt + 1'b1;

         case (nxt_state)
            ST_FOLLOW: begin
               mode <= follow_mode;
               l_in <= (follow_mode == MODE_STOP) ? PIN_COAST : PIN_FWD;
               r_in <= (follow_mode == MODE_STOP) ? PIN_COAST : PIN_FWD;
               if (follow_mode == MODE_LEFT)       last_left <= 1'b1;
               else if (follow_mode == MODE_RIGHT) last_left <= 1'b0;
            end
            ST_LOST: begin
               mode <= last_left ? MODE_LEFT : MODE_RIGHT;
               l_in <= last_left ? PIN_REV : PIN_FWD;
               r_in <= last_left ? PIN_FWD : PIN_REV;
            end
            default: begin
               mode <= MODE_STOP;
               l_in <= PIN_COAST;
               r_in <= PIN_COAST;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_car_drive_controller.sv
`timescale 1ns/1ps
// Directed bench for car_drive_controller with a cycle-level behavioural model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_car_drive_controller;

   localparam int DEB     = 4;
   localparam int CLR     = 8;
   localparam int LOST_TO = 100;
   localparam logic [19:0] STOP_D   = 20'd3000;
   localparam logic [19:0] RESUME_D = 20'd3500;

   localparam logic [2:0] S_IDLE = 3'd0, S_FOLLOW = 3'd1, S_BLOCKED = 3'd2,
                          S_LOST = 3'd3, S_HALT = 3'd4;

   logic        clk = 1'b0;
   logic        rst, en, left_track, mid_track, right_track;
   logic [19:0] distance;
   logic [1:0]  mode, l_in, r_in;
   logic        blocked;
   logic [2:0]  state_dbg;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   car_drive_controller #(
      .DEBOUNCE_CYC(DEB),
      .STOP_DIST   (STOP_D),
      .RESUME_DIST (RESUME_D),
      .CLEAR_CYC   (CLR),
      .LOST_TIMEOUT(LOST_TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .left_track (left_track),
      .mid_track  (mid_track),
      .right_track(right_track),
      .distance   (distance),
      .mode       (mode),
      .l_in       (l_in),
      .r_in       (r_in),
      .blocked    (blocked),
      .state_dbg  (state_dbg)
   );

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [2:0] raw_q[$];
   logic [2:0] syn_q[$];
   logic [2:0] m_state;
   logic [2:0] m_trk;
   int         m_run;
   int         m_lost;
   bit         m_last_left;
   bit         m_valid = 1'b0;
   logic [1:0] e_mode, e_l, e_r;
   bit         e_blocked;

   always @(posedge clk) begin : model_step
      logic [2:0] syn;
      bit obst, clr_now, same;
      syn = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : 3'b000;
      raw_q.push_back({left_track, mid_track, right_track});
      if (raw_q.size() > 2) void'(raw_q.pop_front());
      obst    = (distance != 20'd0) && (distance < STOP_D);
      clr_now = (distance == 20'd0) || (distance >= RESUME_D);
      if (!rst) begin
         m_valid = 1'b1;
         m_state = S_IDLE; m_trk = 3'b000; m_run = 0; m_lost = 0; m_last_left = 1'b1;
         syn_q.delete();
      end else begin
         if (!en) m_state = S_IDLE;
         else begin
            case (m_state)
               S_IDLE: m_state = S_FOLLOW;
               S_FOLLOW: begin
                  if (obst) begin m_state = S_BLOCKED; m_run = 0; end
                  else if (m_trk == 3'b000) begin m_state = S_LOST; m_lost = 0; end
               end
               S_BLOCKED: begin
                  if (clr_now) begin
                     m_run++;
                     if (m_run == CLR) m_state = S_FOLLOW;
                  end else m_run = 0;
               end
               S_LOST: begin
                  if (obst) begin m_state = S_BLOCKED; m_run = 0; end
                  else if (m_trk != 3'b000) m_state = S_FOLLOW;
                  else begin
                     m_lost++;
                     if (m_lost == LOST_TO) m_state = S_HALT;
                  end
               end
               default: m_state = m_state;
            endcase
         end
         e_mode = 2'b11; e_l = 2'b00; e_r = 2'b00;
         if (m_state == S_FOLLOW) begin
            if (m_trk == 3'b010 || m_trk == 3'b111 || m_trk == 3'b101) begin
               e_mode = 2'b00; e_l = 2'b01; e_r = 2'b01;
            end else if (m_trk == 3'b100 || m_trk == 3'b110) begin
               e_mode = 2'b01; e_l = 2'b01; e_r = 2'b01; m_last_left = 1'b1;
            end else if (m_trk == 3'b001 || m_trk == 3'b011) begin
               e_mode = 2'b10; e_l = 2'b01; e_r = 2'b01; m_last_left = 1'b0;
            end
         end else if (m_state == S_LOST) begin
            if (m_last_left) begin e_mode = 2'b01; e_l = 2'b10; e_r = 2'b01; end
            else             begin e_mode = 2'b10; e_l = 2'b01; e_r = 2'b10; end
         end
         syn_q.push_back(syn);
         if (syn_q.size() > DEB + 1) void'(syn_q.pop_front());
         same = 1'b1;
         foreach (syn_q[i]) if (syn_q[i] != syn) same = 1'b0;
         if (syn_q.size() == DEB + 1 && same) m_trk = syn;
      end
      if (!rst) begin
         e_mode = 2'b11; e_l = 2'b00; e_r = 2'b00;
      end
      e_blocked = (m_state == S_BLOCKED);
   end

   always @(negedge clk) begin
      if (m_valid) begin
         chk("cyc.state",   {5'd0, state_dbg}, {5'd0, m_state});
         chk("cyc.mode",    {6'd0, mode},      {6'd0, e_mode});
         chk("cyc.l_in",    {6'd0, l_in},      {6'd0, e_l});
         chk("cyc.r_in",    {6'd0, r_in},      {6'd0, e_r});
         chk("cyc.blocked", {7'd0, blocked},   {7'd0, e_blocked});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_track(input logic [2:0] t);
      {left_track, mid_track, right_track} = t;
   endtask

   task automatic expect_out(input string tag, input logic [2:0] st, input logic [1:0] md,
                             input logic [1:0] li, input logic [1:0] ri, input logic bl);
      chk({tag, ".state"},   {5'd0, state_dbg}, {5'd0, st});
      chk({tag, ".mode"},    {6'd0, mode},      {6'd0, md});
      chk({tag, ".l_in"},    {6'd0, l_in},      {6'd0, li});
      chk({tag, ".r_in"},    {6'd0, r_in},      {6'd0, ri});
      chk({tag, ".blocked"}, {7'd0, blocked},   {7'd0, bl});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; en = 1'b0; set_track(3'b010); distance = 20'd5000;
      cyc(5);
      expect_out("reset", S_IDLE, 2'b11, 2'b00, 2'b00, 1'b0);
      rst = 1'b1; cyc(8);
      expect_out("idle_wait", S_IDLE, 2'b11, 2'b00, 2'b00, 1'b0);
      en = 1'b1; cyc(1);
      expect_out("follow_fwd", S_FOLLOW, 2'b00, 2'b01, 2'b01, 1'b0);

      set_track(3'b110); cyc(3); set_track(3'b010); cyc(10);
      expect_out("glitch_ignored", S_FOLLOW, 2'b00, 2'b01, 2'b01, 1'b0);
      set_track(3'b110); cyc(10);
      expect_out("turn_left", S_FOLLOW, 2'b01, 2'b01, 2'b01, 1'b0);
      set_track(3'b010); cyc(10);
      expect_out("back_fwd", S_FOLLOW, 2'b00, 2'b01, 2'b01, 1'b0);

      distance = 20'd3000; cyc(3);
      expect_out("at_stop_dist", S_FOLLOW, 2'b00, 2'b01, 2'b01, 1'b0);
      distance = 20'd2999; cyc(1);
      expect_out("blocked", S_BLOCKED, 2'b11, 2'b00, 2'b00, 1'b1);
      distance = 20'd3200; cyc(5);
      expect_out("hyst_hold", S_BLOCKED, 2'b11, 2'b00, 2'b00, 1'b1);
      distance = 20'd3500; cyc(7);
      distance = 20'd3200; cyc(1);
      expect_out("clear_broken", S_BLOCKED, 2'b11, 2'b00, 2'b00, 1'b1);
      distance = 20'd3500; cyc(7);
      expect_out("clear_7", S_BLOCKED, 2'b11, 2'b00, 2'b00, 1'b1);
      cyc(1);
      expect_out("clear_8", S_FOLLOW, 2'b00, 2'b01, 2'b01, 1'b0);

      distance = 20'd0; cyc(3);
      expect_out("no_echo", S_FOLLOW, 2'b00, 2'b01, 2'b01, 1'b0);
      set_track(3'b011); cyc(10);
      expect_out("turn_right", S_FOLLOW, 2'b10, 2'b01, 2'b01, 1'b0);
      set_track(3'b000); cyc(10);
      expect_out("lost_right", S_LOST, 2'b10, 2'b01, 2'b10, 1'b0);
      set_track(3'b010); cyc(10);
      expect_out("relock", S_FOLLOW, 2'b00, 2'b01, 2'b01, 1'b0);

      set_track(3'b000); cyc(8);
      expect_out("lost_again", S_LOST, 2'b10, 2'b01, 2'b10, 1'b0);
      cyc(99);
      chk("lost_99.state", {5'd0, state_dbg}, {5'd0, S_LOST});
      cyc(1);
      expect_out("halt", S_HALT, 2'b11, 2'b00, 2'b00, 1'b0);
      set_track(3'b010); cyc(10);
      expect_out("halt_hold", S_HALT, 2'b11, 2'b00, 2'b00, 1'b0);
      en = 1'b0; cyc(1);
      expect_out("halt_to_idle", S_IDLE, 2'b11, 2'b00, 2'b00, 1'b0);
      en = 1'b1; cyc(1);
      expect_out("restart", S_FOLLOW, 2'b00, 2'b01, 2'b01, 1'b0);

      distance = 20'd1000; cyc(1);
      expect_out("blocked2", S_BLOCKED, 2'b11, 2'b00, 2'b00, 1'b1);
      en = 1'b0; cyc(1);
      expect_out("blocked_to_idle", S_IDLE, 2'b11, 2'b00, 2'b00, 1'b0);
      en = 1'b1; distance = 20'd5000; cyc(1);
      expect_out("restart2", S_FOLLOW, 2'b00, 2'b01, 2'b01, 1'b0);

      distance = 20'd1000; cyc(1);
      chk("blocked3.state", {5'd0, state_dbg}, {5'd0, S_BLOCKED});
      set_track(3'b000); cyc(10);
      chk("blocked_noline.state", {5'd0, state_dbg}, {5'd0, S_BLOCKED});
      distance = 20'd5000; cyc(7);
      chk("unblock_7.state", {5'd0, state_dbg}, {5'd0, S_BLOCKED});
      cyc(1);
      chk("unblock_8.state", {5'd0, state_dbg}, {5'd0, S_FOLLOW});
      chk("unblock_8.blocked", {7'd0, blocked}, 8'd0);
      cyc(1);
      expect_out("follow_then_lost", S_LOST, 2'b10, 2'b01, 2'b10, 1'b0);
      en = 1'b0; cyc(1);
      expect_out("lost_to_idle", S_IDLE, 2'b11, 2'b00, 2'b00, 1'b0);

      en = 1'b1; cyc(1);
      chk("reen.state", {5'd0, state_dbg}, {5'd0, S_FOLLOW});
      cyc(1);
      chk("reen_lost.state", {5'd0, state_dbg}, {5'd0, S_LOST});
      set_track(3'b100); cyc(10);
      expect_out("turn_left2", S_FOLLOW, 2'b01, 2'b01, 2'b01, 1'b0);
      set_track(3'b000); cyc(10);
      expect_out("lost_left", S_LOST, 2'b01, 2'b10, 2'b01, 1'b0);
      rst = 1'b0; cyc(1);
      expect_out("mid_reset", S_IDLE, 2'b11, 2'b00, 2'b00, 1'b0);
      cyc(2);
      expect_out("reset_hold", S_IDLE, 2'b11, 2'b00, 2'b00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
